// File: rtl/barrido_pantalla_pkg.sv
// barrido_pantalla_pkg: shared geometry, LCD command bytes and sequencer state encodings
package barrido_pantalla_pkg;
   localparam int LCD_W     = 84;
   localparam int LCD_BANKS = 6;
   localparam int ROW_W     = 6;
   localparam int COL_W     = 7;
   localparam int N_INIT    = 6;
   localparam logic [7:0] CMD_SET_X = 8'h80;
   localparam logic [7:0] CMD_SET_Y = 8'h40;
   localparam logic [2:0] S_LCD_RST = 3'd0;
   localparam logic [2:0] S_INIT    = 3'd1;
   localparam logic [2:0] S_IDLE    = 3'd2;
   localparam logic [2:0] S_XY      = 3'd3;
   localparam logic [2:0] S_FETCH   = 3'd4;
   localparam logic [2:0] S_SEND    = 3'd5;
   localparam logic [2:0] S_NEXT    = 3'd6;
   // Init list: extended set, contrast, temp coeff, bias, basic set, normal display.
   function automatic logic [7:0] init_cmd(input logic [2:0] i, input logic [7:0] vop);
      return i == 3'd0 ? 8'h21 : i == 3'd1 ? vop : i == 3'd2 ? 8'h04 :
             i == 3'd3 ? 8'h14 : i == 3'd4 ? 8'h20 : 8'h0C;
   endfunction
endpackage

// File: rtl/barrido_pantalla_if.sv
// barrido_pantalla_if: frame-RAM read port, refresh handshake and LCD pins
//   master: the scanner (drives busy/done, RAM read strobe/address, LCD pins)
//   slave : the environment (drives start and the RAM pixel)
interface barrido_pantalla_if;
   import barrido_pantalla_pkg::*;
   logic                   start;
   logic                   busy;
   logic                   done;
   logic                   rdRAM;
   logic [ROW_W+COL_W-1:0] addrRAM;
   logic                   doutRAM;
   logic                   lcd_rst_n;
   logic                   lcd_ce;
   logic                   lcd_dc;
   logic                   lcd_sclk;
   logic                   lcd_mosi;
   modport master(input start, doutRAM,
                  output busy, done, rdRAM, addrRAM, lcd_rst_n, lcd_ce, lcd_dc, lcd_sclk, lcd_mosi);
   modport slave(output start, doutRAM,
                 input busy, done, rdRAM, addrRAM, lcd_rst_n, lcd_ce, lcd_dc, lcd_sclk, lcd_mosi);
endinterface

// File: rtl/barrido_pantalla_spi_byte_tx.sv
// spi_byte_tx: write-only SPI mode-0 byte sender, MSB first, CLK_DIV clk per SCLK half-period
//   clk, rst (async, active low)
//   load_i/byte_i/dc_i : accept a byte when ready_o is high
//   ready_o            : idle, or in the last cycle of the inter-byte gap
//   sclk_o/mosi_o/ce_o/dc_o : LCD serial pins
module spi_byte_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   input  logic       dc_i,
   output logic       ready_o,
   output logic       sclk_o,
   output logic       mosi_o,
   output logic       ce_o,
   output logic       dc_o
);
   localparam int DW = $clog2(CLK_DIV + 1);
   logic          act_q, gap_q, hi_q, dc_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q;
   logic [DW-1:0] div_q;
   logic          last;
   assign last    = div_q == DW'(CLK_DIV - 1);
   // Accepting in the final gap cycle makes back-to-back bytes exactly 17 half-periods apart.
   assign ready_o = !act_q || (gap_q && last);
   assign sclk_o  = hi_q;
   assign mosi_o  = sh_q[7];
   assign ce_o    = !act_q || gap_q;
   assign dc_o    = dc_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         act_q <= 1'b0;
         gap_q <= 1'b0;
         hi_q  <= 1'b0;
         dc_q  <= 1'b0;
         bit_q <= '0;
         sh_q  <= '0;
         div_q <= '0;
      end else if (load_i && ready_o) begin
         act_q <= 1'b1;
         gap_q <= 1'b0;
         hi_q  <= 1'b0;
         dc_q  <= dc_i;
         bit_q <= '0;
         sh_q  <= byte_i;
         div_q <= '0;
      end else if (act_q) begin
         div_q <= last ? '0 : div_q + 1'b1;
         if (last) begin
            if (gap_q) begin
               act_q <= 1'b0;
               gap_q <= 1'b0;
            end else if (!hi_q) begin
               hi_q <= 1'b1;
            end else begin
               // Shift on the falling edge so mosi only moves while sclk is low.
               hi_q  <= 1'b0;
               sh_q  <= {sh_q[6:0], 1'b0};
               bit_q <= bit_q + 1'b1;
               gap_q <= bit_q == 3'd7;
            end
         end
      end
endmodule

// File: rtl/barrido_pantalla.sv
// barrido_pantalla: scans the 1-bpp frame RAM into PCD8544 vertical bytes and streams them over SPI
//   clk, rst (async, active low)
//   bus (master): start/busy/done refresh handshake, rdRAM/addrRAM/doutRAM frame-RAM port,
//                 lcd_rst_n/lcd_ce/lcd_dc/lcd_sclk/lcd_mosi LCD pins
module barrido_pantalla
   import barrido_pantalla_pkg::*;
#(
   parameter int         CLK_DIV        = 4,
   parameter int         LCD_RST_CYCLES = 16,
   parameter logic [7:0] VOP            = 8'hB1
) (
   input logic clk,
   input logic rst,
   barrido_pantalla_if.master bus
);
   localparam int RW = $clog2(LCD_RST_CYCLES + 1);
   logic [2:0]       st_q, st_d, idx_q, idx_d, bank_q, bank_d;
   logic [RW-1:0]    cnt_q, cnt_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [3:0]       f_q, f_d;
   logic [7:0]       byte_q, byte_d, tx_byte;
   logic             pend_q, pend_d, done_q, done_d;
   logic             load, tx_dc, tx_ready, col_end;
   assign col_end     = col_q == COL_W'(LCD_W - 1);
   assign bus.busy    = st_q != S_IDLE;
   assign bus.done    = done_q;
   assign bus.rdRAM   = st_q == S_FETCH && !f_q[3];
   // Bank base row is 8*bank, so the row is simply {bank, i}.
   assign bus.addrRAM = bus.rdRAM ? {bank_q, f_q[2:0], col_q} : '0;
   assign bus.lcd_rst_n = st_q != S_LCD_RST;
   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bank_d  = bank_q;
      col_d   = col_q;
      f_d     = f_q;
      byte_d  = byte_q;
      pend_d  = pend_q || (bus.start && (st_q == S_LCD_RST || st_q == S_INIT));
      done_d  = 1'b0;
      load    = 1'b0;
      tx_byte = 8'h00;
      tx_dc   = 1'b0;
      case (st_q)
         S_LCD_RST: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == RW'(LCD_RST_CYCLES - 1)) st_d = S_INIT;
         end
         S_INIT:
            // Extra step after the last command waits for it to leave the wire before idling.
            if (tx_ready) begin
               if (idx_q == 3'(N_INIT)) begin
                  st_d  = S_IDLE;
                  idx_d = '0;
               end else begin
                  load    = 1'b1;
                  tx_byte = init_cmd(idx_q, VOP);
                  idx_d   = idx_q + 1'b1;
               end
            end
         S_IDLE:
            if ((bus.start && !done_q) || pend_q) begin
               st_d   = S_XY;
               pend_d = 1'b0;
               bank_d = '0;
               col_d  = '0;
            end
         S_XY:
            if (tx_ready) begin
               load    = 1'b1;
               tx_byte = idx_q[0] ? CMD_SET_Y : CMD_SET_X;
               idx_d   = {2'b00, ~idx_q[0]};
               st_d    = idx_q[0] ? S_FETCH : S_XY;
               f_d     = '0;
            end
         S_FETCH: begin
            // Pixel for read i arrives one cycle later and lands in bit i.
            f_d = f_q + 1'b1;
            if (f_q != 4'd0) byte_d[f_q[2:0] - 3'd1] = bus.doutRAM;
            if (f_q == 4'd8) st_d = S_SEND;
         end
         S_SEND:
            if (tx_ready) begin
               load    = 1'b1;
               tx_byte = byte_q;
               tx_dc   = 1'b1;
               st_d    = S_NEXT;
            end
         S_NEXT:
            if (bank_q == 3'(LCD_BANKS - 1) && col_end) begin
               if (tx_ready) begin
                  done_d = 1'b1;
                  st_d   = S_IDLE;
               end
            end else begin
               st_d   = S_FETCH;
               f_d    = '0;
               col_d  = col_end ? '0 : col_q + 1'b1;
               bank_d = col_end ? bank_q + 1'b1 : bank_q;
            end
         default: st_d = S_LCD_RST;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st_q   <= S_LCD_RST;
         cnt_q  <= '0;
         idx_q  <= '0;
         bank_q <= '0;
         col_q  <= '0;
         f_q    <= '0;
         byte_q <= '0;
         pend_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         bank_q <= bank_d;
         col_q  <= col_d;
         f_q    <= f_d;
         byte_q <= byte_d;
         pend_q <= pend_d;
         done_q <= done_d;
      end
   spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .byte_i  (tx_byte),
      .dc_i    (tx_dc),
      .ready_o (tx_ready),
      .sclk_o  (bus.lcd_sclk),
      .mosi_o  (bus.lcd_mosi),
      .ce_o    (bus.lcd_ce),
      .dc_o    (bus.lcd_dc)
   );
endmodule

// File: doc/barrido_pantalla.md
Name: barrido_pantalla

Overview:
- Downstream consumer of the 1-bpp frame RAM that the glyph writer fills.
- Reads the RAM through its second port and packs pixels into the PCD8544 vertical-byte format (84x48, 6 banks of 8 rows).
- Streams the bytes to the LCD over a write-only SPI link; also resets and initialises the LCD after system reset.
- Sits between the frame RAM and the LCD pins.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period (≥1).
- LCD_RST_CYCLES, 16: clk cycles lcd_rst_n is held low after reset release.
- VOP, 8'hB1: contrast command byte in the init sequence.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request for a full-frame refresh.
- busy  out  1  high during LCD init or a frame transfer.
- done  out  1  one-cycle pulse after the last data byte of a frame.
- rdRAM  out  1  frame-RAM read strobe.
- addrRAM  out  13  frame-RAM address {row[5:0], col[6:0]}.
- doutRAM  in  1  RAM pixel; valid the cycle after rdRAM (synchronous read).
- lcd_rst_n  out  1  LCD reset, active low.
- lcd_ce  out  1  LCD chip enable, active low.
- lcd_dc  out  1  0 = command, 1 = data.
- lcd_sclk  out  1  SPI clock; idles low.
- lcd_mosi  out  1  SPI data, MSB first.

Behaviour:
- Reset (rst=0, asynchronous) sets outputs to:
  - busy=1, done=0, rdRAM=0, addrRAM=0.
  - lcd_rst_n=0, lcd_ce=1, lcd_dc=0, lcd_sclk=0, lcd_mosi=0.
  - Internal state = S_LCD_RST; the start-pending flag is cleared.
  - Reset mid-byte aborts the transfer immediately; ce rises at once.
- States:
  - S_LCD_RST: hold lcd_rst_n=0 for LCD_RST_CYCLES cycles after rst rises, then drive lcd_rst_n=1 → S_INIT.
  - S_INIT: send commands 0x21, VOP, 0x04, 0x14, 0x20, 0x0C with dc=0, then → S_IDLE.
  - S_IDLE: busy=0. If start=1 or the pending flag is set → S_XY, busy=1, pending cleared.
  - S_XY: send commands 0x80 then 0x40 with dc=0; bank=0, col=0 → S_FETCH.
  - S_FETCH: issue 8 consecutive reads (rdRAM=1 for 8 cycles), i=0..7, addrRAM={8*bank+i, col}. Capture doutRAM into byte bit i one cycle after each read. 9 cycles total → S_SEND.
  - S_SEND: send the byte with dc=1 → S_NEXT.
  - S_NEXT: advance col, wrapping 83→0 and incrementing bank. If bank=5 and col=83 were just sent: done=1 for 1 cycle → S_IDLE. Otherwise → S_FETCH.
- start handling:
  - A start pulse during S_LCD_RST or S_INIT sets the pending flag; the request is served after init.
  - start during a frame (S_XY..S_NEXT) is ignored.
  - start coinciding with done is ignored.
- Byte transmission (SPI mode 0):
  - ce falls and dc/mosi(bit7) become valid together.
  - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; mosi changes only while sclk is low.
  - After bit0 the high phase ends, sclk returns low, and ce stays high for CLK_DIV cycles before the next byte.
  - Byte time = 17*CLK_DIV cycles. dc is stable for the whole time ce is low.
- A frame is 2 command bytes plus 504 data bytes. Pixel (row r, col c) maps to data byte index (r/8)*84 + c, bit r%8.
- All arithmetic on row/col is unsigned. Row max is 47 and col max is 83, so addrRAM never exceeds 6099.

Decomposition:
- Shared package:
  - Geometry constants: LCD_W=84, LCD_BANKS=6, ROW_W=6, COL_W=7.
  - Command constants: the init command list and the set-X/set-Y command bases.
  - State encodings.
- One sub-module, spi_byte_tx:
  - Inputs: load, byte[7:0], dc, CLK_DIV parameter.
  - Outputs: ready, sclk, mosi, ce, dc.
  - Contains the half-period divider and the 3-bit bit counter.
- Top level: sequencer FSM, fetch counter and byte assembler.

Test Plan:
- Reset release → lcd_rst_n low exactly 16 cycles, then the SPI monitor decodes commands 0x21,0xB1,0x04,0x14,0x20,0x0C with dc=0; busy falls after the last byte.
- start in IDLE, RAM with rows 0,2,5,7 of col 0 set → commands 0x80,0x40, then first data byte 0xA5 (dc=1). First fetch addresses 0x0000,0x0080,…,0x0380.
- Full frame with a checkerboard RAM → 504 data bytes alternating 0x55/0xAA per column. Last fetch address 6099 ({47,83}); done pulses once, 1 cycle.
- start pulse at cycle 5 after reset release → served after init completes. start mid-frame → no second frame; exactly 504 data bytes.
- rst asserted mid-byte → same cycle: lcd_ce=1, lcd_sclk=0, lcd_rst_n=0, busy=1. After release the init sequence restarts from 0x21.
- CLK_DIV=1 and CLK_DIV=4 → sclk half-period 1 and 4 cycles; byte time 17 and 68 cycles; mosi never changes while sclk=1.
